// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encodings
// and the architectural zero register index.
package pipeline_pkg;

  typedef enum logic [1:0] {
    HCU_RUN      = 2'd0,
    HCU_LU_STALL = 2'd1,
    HCU_FLUSH    = 2'd2
  } hcu_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard bundle between the pipeline registers and the hazard unit.
// master: pipeline side (drives hazard info); slave: hazard unit.
interface hazard_control_unit_if;
  logic       mem_read;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       mem_access;
  logic       branch_taken;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_bubble;

  modport master (
    output mem_read, rd, rs1, rs2,
    output uses_rs1, uses_rs2,
    output mem_access, branch_taken,
    input  pc_write, if_id_write,
    input  if_id_flush, id_ex_bubble
  );

  modport slave (
    input  mem_read, rd, rs1, rs2,
    input  uses_rs1, uses_rs2,
    input  mem_access, branch_taken,
    output pc_write, if_id_write,
    output if_id_flush, id_ex_bubble
  );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter, stops at all-ones.
// Ports: clk, rst_n (async low), inc, count[W-1:0].
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller: load-use, shared-memory and branch hazards.
// Ports: hazard inputs, PC/IF-ID/ID-EX controls, perf counters, state.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RegisterRd,
  input  logic [4:0]       IF_ID_RegisterRs1,
  input  logic [4:0]       IF_ID_RegisterRs2,
  input  logic             IF_ID_UsesRs1,
  input  logic             IF_ID_UsesRs2,
  input  logic             EX_MEM_MemAccess,
  input  logic             branch_taken,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state_o
);

  localparam logic [2:0] FC_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit         FC_MULTI = (FLUSH_CYCLES > 1);

  hcu_state_t state, state_nxt;
  logic [2:0] fcnt, fcnt_nxt;

  logic lu_hazard;
  logic st_hazard;
  logic br_flush;

  assign lu_hazard = ID_EX_MemRead
    && (ID_EX_RegisterRd != REG_ZERO)
    && ((IF_ID_UsesRs1
         && (ID_EX_RegisterRd == IF_ID_RegisterRs1))
     || (IF_ID_UsesRs2
         && (ID_EX_RegisterRd == IF_ID_RegisterRs2)));

  assign st_hazard = EX_MEM_MemAccess;

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    br_flush     = 1'b0;
    state_nxt    = HCU_RUN;
    fcnt_nxt     = '0;
    if (rst_n) begin
      case (state)
        HCU_RUN, HCU_LU_STALL: begin
          if (branch_taken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            br_flush     = 1'b1;
            if (FC_MULTI) begin
              state_nxt = HCU_FLUSH;
              fcnt_nxt  = FC_LOAD;
            end
          end else if (lu_hazard
                       && (state == HCU_RUN)) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            state_nxt    = HCU_LU_STALL;
          end else if (st_hazard) begin
            // lost fetch slot: hold PC, NOP into IF/ID
            PCWrite     = 1'b0;
            IF_ID_Flush = 1'b1;
          end
        end
        HCU_FLUSH: begin
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
          br_flush     = 1'b1;
          if (fcnt > 3'd1) begin
            state_nxt = HCU_FLUSH;
            fcnt_nxt  = 3'(fcnt - 3'd1);
          end
        end
        default: begin
          state_nxt = HCU_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HCU_RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  assign state_o = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!PCWrite),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (br_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: two configurations
// (FLUSH_CYCLES=1/CNT_W=32 and FLUSH_CYCLES=3/CNT_W=4).
module tb_hazard_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_control_unit_if ia ();
  hazard_control_unit_if ib ();

  logic [31:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;
  logic [1:0]  st_a, st_b;

  hazard_control_unit #(.FLUSH_CYCLES(1), .CNT_W(32)) dut_a (
    .clk               (clk),
    .rst_n             (rst_n),
    .ID_EX_MemRead     (ia.mem_read),
    .ID_EX_RegisterRd  (ia.rd),
    .IF_ID_RegisterRs1 (ia.rs1),
    .IF_ID_RegisterRs2 (ia.rs2),
    .IF_ID_UsesRs1     (ia.uses_rs1),
    .IF_ID_UsesRs2     (ia.uses_rs2),
    .EX_MEM_MemAccess  (ia.mem_access),
    .branch_taken      (ia.branch_taken),
    .PCWrite           (ia.pc_write),
    .IF_ID_Write       (ia.if_id_write),
    .IF_ID_Flush       (ia.if_id_flush),
    .ID_EX_Bubble      (ia.id_ex_bubble),
    .stall_count       (sc_a),
    .flush_count       (fc_a),
    .state_o           (st_a)
  );

  hazard_control_unit #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk               (clk),
    .rst_n             (rst_n),
    .ID_EX_MemRead     (ib.mem_read),
    .ID_EX_RegisterRd  (ib.rd),
    .IF_ID_RegisterRs1 (ib.rs1),
    .IF_ID_RegisterRs2 (ib.rs2),
    .IF_ID_UsesRs1     (ib.uses_rs1),
    .IF_ID_UsesRs2     (ib.uses_rs2),
    .EX_MEM_MemAccess  (ib.mem_access),
    .branch_taken      (ib.branch_taken),
    .PCWrite           (ib.pc_write),
    .IF_ID_Write       (ib.if_id_write),
    .IF_ID_Flush       (ib.if_id_flush),
    .ID_EX_Bubble      (ib.id_ex_bubble),
    .stall_count       (sc_b),
    .flush_count       (fc_b),
    .state_o           (st_b)
  );

  typedef struct {
    bit          sel;
    string       name;
    logic [3:0]  ctl;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}
  localparam logic [3:0] N  = 4'b1100;
  localparam logic [3:0] LS = 4'b0001;
  localparam logic [3:0] ST = 4'b0110;
  localparam logic [3:0] BR = 4'b1111;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [69:0] act, req;
      e = q.pop_front();
      if (e.sel)
        act = {ib.pc_write, ib.if_id_write,
               ib.if_id_flush, ib.id_ex_bubble,
               st_b, 28'd0, sc_b, 28'd0, fc_b};
      else
        act = {ia.pc_write, ia.if_id_write,
               ia.if_id_flush, ia.id_ex_bubble,
               st_a, sc_a, fc_a};
      req = {e.ctl, e.st, e.sc, e.fc};
      total++;
      if (act !== req) begin
        bad++;
        $display("FAIL %s: got ctl=%b st=%0d sc=%0d fc=%0d, want ctl=%b st=%0d sc=%0d fc=%0d",
                 e.name, act[69:66], act[65:64], act[63:32],
                 act[31:0], e.ctl, e.st, e.sc, e.fc);
      end
    end
  end

  task automatic drive(input bit sel, input logic mr,
                       input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic u1,
                       input logic u2, input logic ma,
                       input logic br);
    ia.mem_read = 0; ia.rd = 0; ia.rs1 = 0; ia.rs2 = 0;
    ia.uses_rs1 = 0; ia.uses_rs2 = 0;
    ia.mem_access = 0; ia.branch_taken = 0;
    ib.mem_read = 0; ib.rd = 0; ib.rs1 = 0; ib.rs2 = 0;
    ib.uses_rs1 = 0; ib.uses_rs2 = 0;
    ib.mem_access = 0; ib.branch_taken = 0;
    if (sel) begin
      ib.mem_read = mr; ib.rd = rd; ib.rs1 = r1; ib.rs2 = r2;
      ib.uses_rs1 = u1; ib.uses_rs2 = u2;
      ib.mem_access = ma; ib.branch_taken = br;
    end else begin
      ia.mem_read = mr; ia.rd = rd; ia.rs1 = r1; ia.rs2 = r2;
      ia.uses_rs1 = u1; ia.uses_rs2 = u2;
      ia.mem_access = ma; ia.branch_taken = br;
    end
  endtask

  task automatic step(input bit sel, input string nm,
                      input logic mr, input logic [4:0] rd,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic u1, input logic u2,
                      input logic ma, input logic br,
                      input logic [3:0] ctl, input logic [1:0] st,
                      input int sc, input int fc);
    exp_t e;
    drive(sel, mr, rd, r1, r2, u1, u2, ma, br);
    e.sel = sel; e.name = nm; e.ctl = ctl; e.st = st;
    e.sc = sc; e.fc = fc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    step(0, "a_idle",    0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 0);
    step(0, "a_lu_rs1",  1, 5, 5, 0, 1, 0, 0, 0, LS, 0, 0, 0);
    step(0, "a_lu_done", 1, 5, 5, 0, 1, 0, 0, 0, N, 1, 1, 0);
    step(0, "a_after",   0, 0, 0, 0, 0, 0, 0, 0, N, 0, 1, 0);
    step(0, "a_x0",      1, 0, 0, 0, 1, 1, 0, 0, N, 0, 1, 0);
    step(0, "a_rs2_off", 1, 7, 0, 7, 0, 0, 0, 0, N, 0, 1, 0);
    step(0, "a_lu_rs2",  1, 7, 0, 7, 0, 1, 0, 0, LS, 0, 1, 0);
    step(0, "a_rs2_done",0, 0, 0, 0, 0, 0, 0, 0, N, 1, 2, 0);
    step(0, "a_br_lu",   1, 5, 5, 0, 1, 0, 0, 1, BR, 0, 2, 0);
    step(0, "a_after_br",0, 0, 0, 0, 0, 0, 0, 0, N, 0, 2, 1);
    step(0, "a_st1",     0, 0, 0, 0, 0, 0, 1, 0, ST, 0, 2, 1);
    step(0, "a_st2",     0, 0, 0, 0, 0, 0, 1, 0, ST, 0, 3, 1);
    step(0, "a_st_done", 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 4, 1);
    step(0, "a_lu3",     1, 9, 0, 9, 0, 1, 0, 0, LS, 0, 4, 1);
    step(0, "a_lu3_st",  1, 9, 0, 9, 0, 1, 1, 0, ST, 1, 5, 1);
    step(0, "a_lu4",     1, 9, 9, 0, 1, 0, 0, 0, LS, 0, 6, 1);
    step(0, "a_lu4_br",  1, 9, 9, 0, 1, 0, 0, 1, BR, 1, 7, 1);
    step(0, "a_br_st",   0, 0, 0, 0, 0, 0, 1, 1, BR, 0, 7, 2);
    step(0, "a_end",     0, 0, 0, 0, 0, 0, 0, 0, N, 0, 7, 3);

    step(1, "b_idle",    0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 0);
    step(1, "b_br",      0, 0, 0, 0, 0, 0, 0, 1, BR, 0, 0, 0);
    step(1, "b_fl1_br",  0, 0, 0, 0, 0, 0, 0, 1, BR, 2, 0, 1);
    step(1, "b_fl2",     0, 0, 0, 0, 0, 0, 0, 0, BR, 2, 0, 2);
    step(1, "b_run",     0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 3);
    for (int i = 0; i < 20; i++)
      step(1, "b_sat", 0, 0, 0, 0, 0, 0, 1, 0,
           ST, 0, (i > 15) ? 15 : i, 3);
    step(1, "b_sat_end", 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 15, 3);
    step(1, "b_br2",     0, 0, 0, 0, 0, 0, 0, 1, BR, 0, 15, 3);
    step(1, "b_fl_mid",  0, 0, 0, 0, 0, 0, 0, 0, BR, 2, 15, 4);
    rst_n = 1'b0;
    step(1, "b_in_rst",  1, 3, 3, 0, 1, 0, 1, 1, N, 0, 0, 0);
    rst_n = 1'b1;
    step(1, "b_post_rst",0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0, 0);
    step(1, "b_br3",     0, 0, 0, 0, 0, 0, 0, 1, BR, 0, 0, 0);
    step(1, "b_br3_fl",  0, 0, 0, 0, 0, 0, 0, 0, BR, 2, 0, 1);

    for (int k = 0; k < 4 && q.size() > 0; k++)
      @(posedge clk);
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Central stall/flush controller for the single-memory 5-stage RV32 pipeline. It generates the freeze, bubble and flush controls that the forwarding logic cannot cover.
- Covers three cases:
  - load-use hazards (ID needs a load result still in EX);
  - single-memory structural conflicts (a MEM-stage load/store steals the fetch port);
  - taken-branch flushes (resolved in EX).
- Sits between the ID/EX and EX/MEM pipeline registers and the PC/IF-ID write enables.
- Keeps saturating stall and flush performance counters.

Parameters:
- FLUSH_CYCLES, 1, cycles the FLUSH state holds flush outputs after a taken branch (1..7)
- CNT_W, 32, width of the performance counters

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_RegisterRd  input  5  destination register of the instruction in EX
- IF_ID_RegisterRs1  input  5  rs1 of the instruction in ID
- IF_ID_RegisterRs2  input  5  rs2 of the instruction in ID
- IF_ID_UsesRs1  input  1  ID instruction reads rs1
- IF_ID_UsesRs2  input  1  ID instruction reads rs2
- EX_MEM_MemAccess  input  1  instruction in MEM does a load or store on the shared memory
- branch_taken  input  1  taken branch/jump resolved in EX this cycle
- PCWrite  output  1  PC update enable
- IF_ID_Write  output  1  IF/ID register write enable
- IF_ID_Flush  output  1  load NOP into IF/ID
- ID_EX_Bubble  output  1  zero ID/EX control signals
- stall_count  output  CNT_W  cycles spent stalled (load-use + structural)
- flush_count  output  CNT_W  cycles with flush asserted
- state_o  output  2  current FSM state, for debug

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RUN, flush counter=0, stall_count=0, flush_count=0.
  - Outputs forced: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0.
- Reset deasserting mid-stall or mid-flush returns to RUN with no residual flush.
- Hazard terms:
  - lu_hazard = ID_EX_MemRead & ID_EX_RegisterRd!=0 & ((IF_ID_UsesRs1 & Rd==Rs1) | (IF_ID_UsesRs2 & Rd==Rs2)).
  - st_hazard = EX_MEM_MemAccess.
- Priority is fixed: branch_taken > lu_hazard > st_hazard. Outputs are Mealy, decoded from the state and the current inputs in the same cycle.
- State RUN:
  - branch_taken: IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1. Next state is FLUSH if FLUSH_CYCLES>1 (counter loaded with FLUSH_CYCLES-1), otherwise RUN.
  - else lu_hazard: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, next state LU_STALL.
  - else st_hazard: PCWrite=0, IF_ID_Write=1, IF_ID_Flush=1. The fetch slot is lost, so IF/ID gets a NOP and the PC holds. Remain in RUN.
  - else: all enables 1, no flush or bubble.
- State LU_STALL (exactly one cycle):
  - lu_hazard is ignored; the load has advanced, so the forwarding path now supplies the value.
  - branch_taken still wins and behaves as in RUN.
  - st_hazard is applied as in RUN. This is the normal case, since the load is now in MEM.
  - Next state is RUN, unless a branch entered FLUSH.
- State FLUSH:
  - IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1.
  - Counter decrements; go to RUN when it reaches 0.
  - branch_taken during FLUSH is ignored, because the EX instruction is a bubble.
- Counters:
  - stall_count increments in every cycle with PCWrite=0.
  - flush_count increments in every cycle with IF_ID_Flush=1 and the cause not st_hazard.
  - Both saturate at all-ones and never wrap.
- Encoding: RUN=2'd0, LU_STALL=2'd1, FLUSH=2'd2. Encoding 3 is illegal and recovers to RUN on the next edge.

Decomposition:
- Shared package `pipeline_pkg` holds:
  - the state encodings `HCU_RUN`, `HCU_LU_STALL`, `HCU_FLUSH`;
  - the constant `REG_ZERO`=5'd0.
- Sub-module: `sat_counter` (parameter W; ports inc, count; saturating, async active-low reset), instantiated twice.
- All hazard compare logic stays inline.

Test Plan:
- Load x5 in EX, ID reads rs1=x5 with UsesRs1=1 -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, state_o=1. Next cycle it is in RUN with no further stall; stall_count=1.
- Load to x0 in EX, ID reads x0 -> no stall; stall_count stays 0.
- branch_taken together with lu_hazard, FLUSH_CYCLES=1 -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1; no stall; flush_count=1.
- FLUSH_CYCLES=3, branch_taken pulse -> flush held 3 consecutive cycles; a second branch_taken in cycle 2 is ignored; flush_count=3.
- EX_MEM_MemAccess=1 for 2 cycles in RUN -> PCWrite=0 and IF_ID_Flush=1 each cycle; stall_count=2; flush_count=0.
- rst_n asserted in the middle of FLUSH; CNT_W=4 run for 20 stall cycles -> after reset, state=RUN and outputs at reset values; stall_count saturates at 15.
